accel_sample_scheduler: RTL and testbench
=========================================

Name: accel_sample_scheduler

Overview:
- Sequences periodic accelerometer reads and hands each completed X/Y/Z sample to the beat generator as a one-cycle qualified strobe.
- Replaces the divided 10 ms clock with a single-clock tick/enable scheme.
- Sits between the I2C accelerometer reader (request/busy/done handshake) and the beat generator.
- Owns sample timing, timeouts and error/overrun accounting.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 100, sample rate (10 ms period).
- TICK_DIV, CLK_HZ/SAMPLE_HZ, clocks per sample period (must be at least 4).
- TIMEOUT_CYC, 250000, maximum clocks from request to done/err (must be less than TICK_DIV).
- DATA_W, 16, accelerometer axis width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  sampling enable.
- rd_req  out  1  read request to the accelerometer reader.
- rd_busy  in  1  reader has accepted the request and is active.
- rd_done  in  1  one-cycle pulse: x_in/y_in/z_in are valid this cycle.
- rd_err  in  1  one-cycle pulse: read failed (NACK/bus error).
- x_in, y_in, z_in  in  DATA_W each  raw axis data from the reader.
- x_out, y_out, z_out  out  DATA_W each  last good sample, held between updates.
- sample_valid  out  1  one-cycle strobe, cycle after new x/y/z_out load.
- stale  out  1  high after 2 or more consecutive periods without a good sample.
- timeout_cnt  out  8  saturating count of timeouts.
- err_cnt  out  8  saturating count of rd_err events.
- overrun_cnt  out  8  saturating count of ticks dropped because FSM was busy.

Behaviour:
- Reset (async, rst=1):
  - Outputs: all 0.
  - Internal: state=IDLE, tick counter=0, timeout counter=0, miss counter=0.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 while enable=1; tick=1 when count==TICK_DIV-1, then wraps to 0.
  - enable=0: counter held at 0, no ticks.
  - First tick occurs TICK_DIV cycles after enable rises.
- FSM states: IDLE, REQ, WAIT, LATCH.
- IDLE:
  - rd_req=0.
  - tick moves to REQ.
- REQ:
  - rd_req=1 (Moore output).
  - rd_busy=1 moves to WAIT.
  - rd_done=1 here (fast reader) is treated as WAIT+done.
  - Timeout counter cleared on entry.
- WAIT:
  - rd_req=0.
  - rd_err=1: err_cnt+1, miss+1, go to IDLE; outputs not updated.
  - rd_done=1 (and no rd_err): x/y/z_out load x/y/z_in on that edge, go to LATCH.
  - rd_done and rd_err in the same cycle: err wins.
- LATCH:
  - sample_valid=1 for exactly this one cycle.
  - Miss counter cleared, stale cleared.
  - Unconditionally go to IDLE.
- Timeout:
  - Counter increments every cycle in REQ and WAIT.
  - Reaching TIMEOUT_CYC-1 without done/err: timeout_cnt+1, miss+1, go to IDLE.
  - A late rd_done/rd_err arriving in IDLE is ignored.
- Overrun:
  - A tick in REQ, WAIT or LATCH gives overrun_cnt+1 and miss+1.
  - The tick is dropped, never queued.
  - A tick in the same cycle the FSM leaves WAIT still counts as overrun.
- stale: set when miss counter reaches 2; miss counter saturates at 3.
- Counters (timeout_cnt, err_cnt, overrun_cnt): saturate at 255; cleared only by rst.
- enable deasserted mid-transaction: transaction runs to done/err/timeout normally; no further requests.
- Latency: tick to rd_req high is 1 cycle; rd_done to sample_valid is 1 cycle.

Decomposition:
- Package sound_pkg:
  - State enum (IDLE/REQ/WAIT/LATCH).
  - Default CLK_HZ, SAMPLE_HZ, TIMEOUT_CYC.
  - CNT_W=8 counter width.
  - Saturating-increment helper function.
- Sub-module sample_tick_gen:
  - Parameterised divider with enable, producing a one-cycle tick.
  - Replaces scale_clock usage.

Test Plan (TICK_DIV=100, TIMEOUT_CYC=40):
1. Normal: enable=1; model busy 2 cycles after rd_req, done 10 cycles later with x=16'h1234, y=16'hFFFF, z=16'h0000 -> rd_req 1 cycle after tick; sample_valid one cycle after done with outputs equal to those values; repeats every 100 cycles; all counters 0.
2. Timeout: reader never asserts busy -> returns to IDLE 40 cycles after REQ entry, timeout_cnt=1, outputs unchanged; after second period stale=1; next good read clears stale.
3. Error and collision: rd_err alone gives err_cnt=1, no sample_valid; rd_done+rd_err same cycle gives err_cnt=2, no output update.
4. Overrun: reader done 150 cycles after request (TIMEOUT_CYC raised to 200 for this test) -> overrun_cnt=1, next request only on the following tick.
5. Reset and enable: assert rst while in WAIT -> all outputs 0 asynchronously, state IDLE; enable=0 mid-WAIT -> read completes with sample_valid=1, then no rd_req for 500 cycles.
6. Saturation: force 300 errors -> err_cnt stays 255.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types, default timing constants and helpers for the accelerometer sample scheduler.
package sound_pkg;

   localparam int unsigned DEF_CLK_HZ      = 50_000_000;
   localparam int unsigned DEF_SAMPLE_HZ   = 100;
   localparam int unsigned DEF_TIMEOUT_CYC = 250_000;
   localparam int unsigned CNT_W           = 8;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_REQ   = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_LATCH = 2'd3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Single-clock divider: one-cycle tick every TICK_DIV clocks while enabled.
module sample_tick_gen #(
   parameter int unsigned TICK_DIV = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick_c
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   always_comb begin
      cnt_d  = cnt_q;
      wrap   = (cnt_q == CW'(TICK_DIV - 1));
      tick_c = enable && wrap;
      if (!enable || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/accel_sample_scheduler.sv
// Periodic accelerometer read sequencer with timeout, error, overrun and staleness tracking.
module accel_sample_scheduler
   import sound_pkg::*;
#(
   parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
   parameter int unsigned SAMPLE_HZ   = DEF_SAMPLE_HZ,
   parameter int unsigned TICK_DIV    = CLK_HZ / SAMPLE_HZ,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic              rd_req,
   input  logic              rd_busy,
   input  logic              rd_done,
   input  logic              rd_err,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   input  logic [DATA_W-1:0] z_in,
   output logic [DATA_W-1:0] x_out,
   output logic [DATA_W-1:0] y_out,
   output logic [DATA_W-1:0] z_out,
   output logic              sample_valid,
   output logic              stale,
   output logic [CNT_W-1:0]  timeout_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  overrun_cnt
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic              tick_c;
   state_t            state_q, state_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [1:0]        miss_q, miss_d;
   logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic              rd_req_q, rd_req_d, sample_valid_q, sample_valid_d, stale_q, stale_d;
   logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d, err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  overrun_cnt_q, overrun_cnt_d;
   logic              miss_evt, overrun;

   sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick_c (tick_c)
   );

   // Next-state, datapath and accounting
   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      miss_d        = miss_q;
      x_d           = x_q;
      y_d           = y_q;
      z_d           = z_q;
      timeout_cnt_d = timeout_cnt_q;
      err_cnt_d     = err_cnt_q;
      overrun_cnt_d = overrun_cnt_q;
      miss_evt      = 1'b0;
      overrun       = tick_c && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (tick_c) state_d = ST_REQ;
         end
         ST_REQ, ST_WAIT: begin
            tmo_d = tmo_q + TW'(1);
            if (rd_err) begin
               err_cnt_d = sat_inc(err_cnt_q);
               miss_evt  = 1'b1;
               state_d   = ST_IDLE;
            end else if (rd_done) begin
               // A done seen while still requesting is taken as an immediate completion.
               x_d     = x_in;
               y_d     = y_in;
               z_d     = z_in;
               state_d = ST_LATCH;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               timeout_cnt_d = sat_inc(timeout_cnt_q);
               miss_evt      = 1'b1;
               state_d       = ST_IDLE;
            end else if ((state_q == ST_REQ) && rd_busy) begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            miss_d  = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (overrun) overrun_cnt_d = sat_inc(overrun_cnt_q);
      if (miss_evt && (miss_d != 2'd3)) miss_d = miss_d + 2'd1;
      if (overrun && (miss_d != 2'd3)) miss_d = miss_d + 2'd1;

      stale_d        = (miss_d >= 2'd2);
      rd_req_d       = (state_d == ST_REQ);
      sample_valid_d = (state_d == ST_LATCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         tmo_q          <= '0;
         miss_q         <= '0;
         x_q            <= '0;
         y_q            <= '0;
         z_q            <= '0;
         rd_req_q       <= 1'b0;
         sample_valid_q <= 1'b0;
         stale_q        <= 1'b0;
         timeout_cnt_q  <= '0;
         err_cnt_q      <= '0;
         overrun_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         tmo_q          <= tmo_d;
         miss_q         <= miss_d;
         x_q            <= x_d;
         y_q            <= y_d;
         z_q            <= z_d;
         rd_req_q       <= rd_req_d;
         sample_valid_q <= sample_valid_d;
         stale_q        <= stale_d;
         timeout_cnt_q  <= timeout_cnt_d;
         err_cnt_q      <= err_cnt_d;
         overrun_cnt_q  <= overrun_cnt_d;
      end
   end

   assign rd_req       = rd_req_q;
   assign x_out        = x_q;
   assign y_out        = y_q;
   assign z_out        = z_q;
   assign sample_valid = sample_valid_q;
   assign stale        = stale_q;
   assign timeout_cnt  = timeout_cnt_q;
   assign err_cnt      = err_cnt_q;
   assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_accel_sample_scheduler.sv
// Directed bench: instance a uses TIMEOUT_CYC=40, instance b uses TIMEOUT_CYC=200 (overrun case).
module tb_accel_sample_scheduler;

   logic        clk = 1'b0;
   logic        rst, enable, rd_busy, rd_done, rd_err;
   logic [15:0] x_in, y_in, z_in;

   logic        rd_req_a, sv_a, stale_a;
   logic [15:0] x_a, y_a, z_a;
   logic [7:0]  tmo_a, err_a, ovr_a;
   logic        rd_req_b, sv_b, stale_b;
   logic [15:0] x_b, y_b, z_b;
   logic [7:0]  tmo_b, err_b, ovr_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   accel_sample_scheduler #(.TICK_DIV(100), .TIMEOUT_CYC(40), .DATA_W(16)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .rd_req(rd_req_a), .rd_busy(rd_busy),
      .rd_done(rd_done), .rd_err(rd_err), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .x_out(x_a), .y_out(y_a), .z_out(z_a), .sample_valid(sv_a), .stale(stale_a),
      .timeout_cnt(tmo_a), .err_cnt(err_a), .overrun_cnt(ovr_a)
   );

   accel_sample_scheduler #(.TICK_DIV(100), .TIMEOUT_CYC(200), .DATA_W(16)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .rd_req(rd_req_b), .rd_busy(rd_busy),
      .rd_done(rd_done), .rd_err(rd_err), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .x_out(x_b), .y_out(y_b), .z_out(z_b), .sample_valid(sv_b), .stale(stale_b),
      .timeout_cnt(tmo_b), .err_cnt(err_b), .overrun_cnt(ovr_b)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic req_of(input int which);
      return (which == 1) ? rd_req_b : rd_req_a;
   endfunction

   task automatic wait_req(input int which, input string tag, output int at);
      int n = 0;
      while (req_of(which) !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
      at = cyc;
   endtask

   task automatic wait_fall(input int which, input string tag, output int at);
      int n = 0;
      while (req_of(which) !== 1'b0 && n < 400) begin
         step();
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
      at = cyc;
   endtask

   // Reader model: busy after busy_dly cycles, completion pulse done_dly cycles later.
   task automatic serve(input int busy_dly, input int done_dly, input logic dn, input logic er,
                        input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv);
      repeat (busy_dly) step();
      rd_busy = 1'b1;
      repeat (done_dly) step();
      x_in = xv; y_in = yv; z_in = zv;
      rd_done = dn; rd_err = er;
      step();
      rd_done = 1'b0; rd_err = 1'b0; rd_busy = 1'b0;
   endtask

   initial begin
      int t0, t1, hits;
      rst = 1'b1; enable = 1'b0; rd_busy = 1'b0; rd_done = 1'b0; rd_err = 1'b0;
      x_in = '0; y_in = '0; z_in = '0;
      step(); step();
      check("rst_rd_req", 32'(rd_req_a), 0);
      check("rst_x_out", 32'(x_a), 0);
      check("rst_sv", 32'(sv_a), 0);
      check("rst_cnts", {8'h0, tmo_a, err_a, ovr_a}, 0);
      rst = 1'b0; enable = 1'b1;

      // Normal reads, 100-cycle period
      wait_req(0, "t1_req0_bound", t0);
      check("t1_rd_req", 32'(rd_req_a), 1);
      serve(2, 10, 1'b1, 1'b0, 16'h1234, 16'hFFFF, 16'h0000);
      check("t1_sv", 32'(sv_a), 1);
      check("t1_xyz", {x_a, y_a}, 32'h1234FFFF);
      check("t1_z", 32'(z_a), 0);
      step();
      check("t1_sv_drop", 32'(sv_a), 0);
      wait_req(0, "t1_req1_bound", t1);
      check("t1_period", t1 - t0, 100);
      serve(2, 10, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 16'h8000);
      check("t1_xyz2", {x_a, z_a}, 32'hA5A58000);
      check("t1_cnts", {8'h0, tmo_a, err_a, ovr_a}, 0);

      // Timeout twice -> stale, then good read clears
      wait_req(0, "t2_req_bound", t0);
      wait_fall(0, "t2_fall_bound", t1);
      check("t2_tmo_len", t1 - t0, 40);
      check("t2_tmo_cnt", 32'(tmo_a), 1);
      check("t2_x_hold", 32'(x_a), 32'hA5A5);
      check("t2_stale0", 32'(stale_a), 0);
      wait_req(0, "t2_req2_bound", t0);
      wait_fall(0, "t2_fall2_bound", t1);
      check("t2_tmo_cnt2", 32'(tmo_a), 2);
      check("t2_stale1", 32'(stale_a), 1);
      wait_req(0, "t2_req3_bound", t0);
      serve(2, 10, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 16'h3C3C);
      check("t2_sv", 32'(sv_a), 1);
      step();
      check("t2_stale_clr", 32'(stale_a), 0);

      // Error alone, error+done collision, fast reader
      wait_req(0, "t3_req_bound", t0);
      serve(2, 3, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD);
      check("t3_err1", 32'(err_a), 1);
      check("t3_err_sv", 32'(sv_a), 0);
      wait_req(0, "t3_req2_bound", t0);
      serve(2, 3, 1'b1, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD);
      check("t3_err2", 32'(err_a), 2);
      check("t3_coll_sv", 32'(sv_a), 0);
      check("t3_coll_hold", {x_a, y_a}, 32'h0F0FF0F0);
      wait_req(0, "t3_req3_bound", t0);
      x_in = 16'h1111; y_in = 16'h2222; z_in = 16'h3333; rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      check("t3_fast_sv", 32'(sv_a), 1);
      check("t3_fast_xy", {x_a, z_a}, 32'h11113333);

      // Overrun on instance b (done 150 cycles after request)
      rst = 1'b1; step(); rst = 1'b0;
      wait_req(1, "t4_req_bound", t0);
      serve(2, 148, 1'b1, 1'b0, 16'hBEEF, 16'hCAFE, 16'h0123);
      check("t4_sv", 32'(sv_b), 1);
      check("t4_x", 32'(x_b), 32'hBEEF);
      check("t4_ovr", 32'(ovr_b), 1);
      check("t4_tmo_b", 32'(tmo_b), 0);
      wait_req(1, "t4_req2_bound", t1);
      check("t4_next_req", t1 - t0, 200);

      // Async reset while in WAIT
      step(); step(); rd_busy = 1'b1; step();
      check("t5_pre_busy_rd_req", 32'(rd_req_b), 0);
      #2 rst = 1'b1;
      #1;
      check("t5_async_x_b", 32'(x_b), 0);
      check("t5_async_ovr_b", 32'(ovr_b), 0);
      check("t5_async_tmo_a", 32'(tmo_a), 0);
      check("t5_async_x_a", 32'(x_a), 0);
      rd_busy = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("t5_idle_req", 32'(rd_req_a), 0);

      // enable dropped mid-WAIT: read completes, no more requests
      wait_req(0, "t5_req_bound", t0);
      step(); step(); rd_busy = 1'b1; step();
      enable = 1'b0;
      repeat (5) step();
      x_in = 16'h7777; y_in = 16'h8888; z_in = 16'h9999; rd_done = 1'b1;
      step();
      rd_done = 1'b0; rd_busy = 1'b0;
      check("t5_en_sv", 32'(sv_a), 1);
      check("t5_en_x", 32'(x_a), 32'h7777);
      hits = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (rd_req_a === 1'b1) hits++;
      end
      check("t5_no_req", hits, 0);

      // Error counter saturation
      enable = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wait_req(0, "t6_req_bound", t0);
         step(); rd_busy = 1'b1; step();
         rd_busy = 1'b0; rd_err = 1'b1; step();
         rd_err = 1'b0;
         if (i == 253) check("t6_err254", 32'(err_a), 254);
      end
      check("t6_err_sat", 32'(err_a), 255);
      check("t6_stale", 32'(stale_a), 1);
      check("t6_sv", 32'(sv_a), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
